// File: rtl/exe_muldiv.sv
// rtl/exe_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; optional MULDIV_EARLY_EXIT_EN
module exe_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            Start_IN,
  input  logic [2:0]      Op_IN,
  input  logic [XLEN-1:0] OperandA_IN,
  input  logic [XLEN-1:0] OperandB_IN,
  input  logic            Read_Hilo_IN,
  input  logic            Flush_IN,
  output logic [XLEN-1:0] HI_OUT,
  output logic [XLEN-1:0] LO_OUT,
  output logic            Busy_OUT,
  output logic            Done_OUT,
  output logic            Want_Freeze_OUT
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

`ifdef MULDIV_EARLY_EXIT_EN
  localparam logic EARLY_EXIT = 1'b1;
`else
  localparam logic EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_done;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_div;
  logic              r_neg_q;     // product / quotient must be negated
  logic              r_neg_r;     // remainder must be negated
  logic [2*XLEN-1:0] r_acc;       // product accumulator
  logic [2*XLEN-1:0] r_mcand;     // multiplicand, shifted left each step
  logic [XLEN-1:0]   r_mplier;    // remaining multiplier, or dividend shifting into quotient
  logic [XLEN-1:0]   r_rem;       // partial remainder
  logic [XLEN-1:0]   r_dvsr;      // divisor magnitude

  logic              w_signed_op;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN:0]     w_rem_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_sub;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_remf;
  logic              w_skip;

  assign w_signed_op = (Op_IN == OP_MULT) || (Op_IN == OP_DIV);
  assign w_a_neg     = w_signed_op && OperandA_IN[XLEN-1];
  assign w_b_neg     = w_signed_op && OperandB_IN[XLEN-1];
  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  assign w_a_mag     = w_a_neg ? -OperandA_IN : OperandA_IN;
  assign w_b_mag     = w_b_neg ? -OperandB_IN : OperandB_IN;

  // 33-bit shifted partial remainder; the difference fits XLEN bits whenever it is kept
  assign w_rem_sh    = {r_rem, r_mplier[XLEN-1]};
  assign w_ge        = w_rem_sh >= {1'b0, r_dvsr};
  assign w_sub       = w_rem_sh[XLEN-1:0] - r_dvsr;

  assign w_prod      = r_neg_q ? -r_acc : r_acc;
  assign w_quot      = r_neg_q ? -r_mplier : r_mplier;
  assign w_remf      = r_neg_r ? -r_rem : r_rem;

  assign w_skip      = EARLY_EXIT && !r_is_div && (r_mplier == '0);

  assign HI_OUT          = r_hi;
  assign LO_OUT          = r_lo;
  assign Done_OUT        = r_done;
  assign Busy_OUT        = (r_state != S_IDLE);
  assign Want_Freeze_OUT = Busy_OUT && (Start_IN || Read_Hilo_IN);

  // Control FSM and datapath: accept in IDLE, iterate in RUN, sign-fix and commit in FIX
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_dvsr   <= '0;
    end else begin
      r_done <= 1'b0;
      if (Flush_IN) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (Start_IN) begin
              case (Op_IN)
                OP_MTHI: r_hi <= OperandA_IN;
                OP_MTLO: r_lo <= OperandA_IN;
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                  r_is_div <= Op_IN[1];
                  r_neg_q  <= w_a_neg ^ w_b_neg;
                  r_neg_r  <= w_a_neg;
                  r_cnt    <= '0;
                  r_acc    <= '0;
                  r_rem    <= '0;
                  r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
                  r_mplier <= Op_IN[1] ? w_a_mag : w_b_mag;
                  r_dvsr   <= w_b_mag;
                  r_state  <= S_RUN;
                end
                default: ;
              endcase
            end
          end
          S_RUN: begin
            if (w_skip) begin
              r_state <= S_FIX;
            end else begin
              if (r_is_div) begin
                r_rem    <= w_ge ? w_sub : w_rem_sh[XLEN-1:0];
                r_mplier <= {r_mplier[XLEN-2:0], w_ge};
              end else begin
                if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
              end
              if (r_cnt == LAST_ITER) r_state <= S_FIX;
              else r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_FIX: begin
            if (r_is_div) begin
              r_lo <= w_quot;
              r_hi <= w_remf;
            end else begin
              r_hi <= w_prod[2*XLEN-1:XLEN];
              r_lo <= w_prod[XLEN-1:0];
            end
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exe_muldiv.sv
// tb/tb_exe_muldiv.sv - scoreboard bench for exe_muldiv
module tb_exe_muldiv;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Start_IN;
  logic [2:0]  Op_IN;
  logic [31:0] OperandA_IN;
  logic [31:0] OperandB_IN;
  logic        Read_Hilo_IN;
  logic        Flush_IN;
  logic [31:0] HI_OUT;
  logic [31:0] LO_OUT;
  logic        Busy_OUT;
  logic        Done_OUT;
  logic        Want_Freeze_OUT;

  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0] sb_q[$];

  exe_muldiv dut (
    .CLK(CLK), .RESET(RESET), .Start_IN(Start_IN), .Op_IN(Op_IN),
    .OperandA_IN(OperandA_IN), .OperandB_IN(OperandB_IN),
    .Read_Hilo_IN(Read_Hilo_IN), .Flush_IN(Flush_IN),
    .HI_OUT(HI_OUT), .LO_OUT(LO_OUT), .Busy_OUT(Busy_OUT),
    .Done_OUT(Done_OUT), .Want_Freeze_OUT(Want_Freeze_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Reference results {HI, LO} from native arithmetic plus the documented divide corner cases
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] sa, sb, sq, sr;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) return {a, (a[31] ? 32'h00000001 : 32'hFFFFFFFF)};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        sq = sa / sb;
        sr = sa % sb;
        return {sr, sq};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int exp_busy(input logic [2:0] op, input logic [31:0] b);
    int n;
    logic [31:0] m;
    n = 33;
`ifdef MULDIV_EARLY_EXIT_EN
    if (op <= 3'd1) begin
      m = (op == 3'd0 && b[31]) ? -b : b;
      n = 2;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 3;
      if (n > 33) n = 33;
    end
`else
    m = b;
    if (op > 3'd7 && m != 0) n = 0;
`endif
    return n;
  endfunction

  // Scoreboard: every Done pulse must match the oldest outstanding expectation
  always @(negedge CLK) begin
    if (!RESET && Done_OUT) begin
      if (sb_q.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("sb_hi", HI_OUT, e[63:32]);
        check("sb_lo", LO_OUT, e[31:0]);
      end
    end
  end

  // mode 0: plain, 1: MFHI/MFLO held from E5, 2: MTLO presented while busy
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int mode, input logic [63:0] exp);
    int c;
    @(negedge CLK);
    Start_IN = 1'b1; Op_IN = op; OperandA_IN = a; OperandB_IN = b;
    sb_q.push_back(exp);
    @(negedge CLK);
    Start_IN = 1'b0;
    c = 0;
    while (Busy_OUT && c < 100) begin
      if (mode == 1 && c >= 4) begin
        Read_Hilo_IN = 1'b1;
        #1 check("freeze_read", 32'(Want_Freeze_OUT), 32'd1);
      end
      if (mode == 2 && c == 3) begin
        Start_IN = 1'b1; Op_IN = 3'd5; OperandA_IN = 32'hDEAD;
        #1 check("freeze_mtlo", 32'(Want_Freeze_OUT), 32'd1);
      end
      if (mode == 2 && c == 4) Start_IN = 1'b0;
      @(negedge CLK);
      c++;
    end
    if (mode == 1) begin
      #1 check("freeze_release", 32'(Want_Freeze_OUT), 32'd0);
      Read_Hilo_IN = 1'b0;
    end
    check("busy_cycles", 32'(c), 32'(exp_busy(op, b)));
    check("done_pulse", 32'(Done_OUT), 32'd1);
    @(negedge CLK);
    check("done_clear", 32'(Done_OUT), 32'd0);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] v);
    @(negedge CLK);
    Start_IN = 1'b1; Op_IN = op; OperandA_IN = v;
    @(negedge CLK);
    Start_IN = 1'b0;
    check(op == 3'd4 ? "mthi_val" : "mtlo_val", op == 3'd4 ? HI_OUT : LO_OUT, v);
    check("mt_busy", 32'(Busy_OUT), 32'd0);
  endtask

  task automatic start_mult();
    @(negedge CLK);
    Start_IN = 1'b1; Op_IN = 3'd0; OperandA_IN = 32'h1234567; OperandB_IN = 32'h89ABCDE;
    @(negedge CLK);
    Start_IN = 1'b0;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    RESET = 1'b1; Start_IN = 1'b0; Op_IN = 3'd0; OperandA_IN = '0; OperandB_IN = '0;
    Read_Hilo_IN = 1'b0; Flush_IN = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_hi", HI_OUT, 32'd0);
    check("rst_lo", LO_OUT, 32'd0);
    check("rst_busy", 32'(Busy_OUT), 32'd0);
    check("rst_done", 32'(Done_OUT), 32'd0);
    RESET = 1'b0;

    run_op(3'd0, 32'hFFFFFFFD, 32'd7, 0, {32'hFFFFFFFF, 32'hFFFFFFEB});
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op(3'd3, 32'h10, 32'd0, 0, {32'h10, 32'hFFFFFFFF});
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, {32'hFFFFFFFE, 32'h00000001});
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, {32'h0, 32'h80000000});
    run_op(3'd2, 32'hFFFFFFFB, 32'd0, 0, {32'hFFFFFFFB, 32'h00000001});
    run_op(3'd2, 32'd5, 32'd0, 0, {32'd5, 32'hFFFFFFFF});
    run_op(3'd0, 32'h80000000, 32'h80000000, 0, {32'h40000000, 32'h0});
    run_op(3'd1, 32'd5, 32'd3, 0, {32'd0, 32'd15});
    run_op(3'd1, 32'd9, 32'd0, 0, {32'd0, 32'd0});
    run_op(3'd0, 32'd6, 32'd7, 2, {32'd0, 32'd42});

    mt(3'd4, 32'h1234);
    mt(3'd5, 32'h5678);

    // Flush on the same edge as a start wins
    @(negedge CLK);
    Start_IN = 1'b1; Op_IN = 3'd4; OperandA_IN = 32'h99; Flush_IN = 1'b1;
    @(negedge CLK);
    Start_IN = 1'b0; Flush_IN = 1'b0;
    check("flush_start_hi", HI_OUT, 32'h1234);
    check("flush_start_busy", 32'(Busy_OUT), 32'd0);

    // Flush at E10 leaves HI/LO untouched
    mt(3'd4, 32'd0);
    mt(3'd5, 32'd0);
    start_mult();
    repeat (9) @(negedge CLK);
    Flush_IN = 1'b1;
    @(negedge CLK);
    Flush_IN = 1'b0;
    check("flush_busy", 32'(Busy_OUT), 32'd0);
    check("flush_hi", HI_OUT, 32'd0);
    check("flush_lo", LO_OUT, 32'd0);
    check("flush_done", 32'(Done_OUT), 32'd0);
    repeat (40) @(negedge CLK);
    check("flush_lo_late", LO_OUT, 32'd0);

    // Reset at E20 clears everything
    mt(3'd4, 32'h55);
    mt(3'd5, 32'h66);
    start_mult();
    repeat (19) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("midrst_hi", HI_OUT, 32'd0);
    check("midrst_lo", LO_OUT, 32'd0);
    check("midrst_busy", 32'(Busy_OUT), 32'd0);
    check("midrst_done", 32'(Done_OUT), 32'd0);
    repeat (40) @(negedge CLK);

    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 4 == 0) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom);
      run_op(op, a, b, 0, model(op, a, b));
    end

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
